// File: rtl/corr_pkg.sv
// Shared types and sizing helpers for the streaming correlator.
package corr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Exact result width: full product plus headroom for TAPS additions.
  function automatic int acc_width(int data_w, int coef_w, int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Tap index / fill count width; must be able to hold the value TAPS itself.
  function automatic int idx_width(int taps);
    return $clog2(taps + 1);
  endfunction

  localparam int DEF_TAPS  = 10;
  localparam int DEF_IDX_W = idx_width(DEF_TAPS);

endpackage

// File: rtl/corr_mac.sv
// Single multiply-accumulate unit. The product is registered before the
// accumulate so the multiplier and adder sit in separate cycles.
module corr_mac
  import corr_pkg::*;
#(
  parameter int A_W    = 4,
  parameter int B_W    = 4,
  parameter int ACC_W  = 12,
  parameter int SIGNED = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] a_x;
  logic [ACC_W-1:0] b_x;
  logic [ACC_W-1:0] prod;
  logic             prod_vld;

  // Widen operands to the accumulator width; the low ACC_W bits of the
  // product are then correct for both signed and unsigned operands.
  always_comb begin
    if (SIGNED != 0) begin
      a_x = ACC_W'($signed(a));
      b_x = ACC_W'($signed(b));
    end else begin
      a_x = ACC_W'(a);
      b_x = ACC_W'(b);
    end
  end

  // Product register followed by the accumulator.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else if (clr) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= en;
      if (en) prod <= a_x * b_x;
      if (prod_vld) acc <= acc + prod;
    end
  end

endmodule

// File: rtl/correlation_stream.sv
// Streaming TAPS-deep correlator with runtime-loadable coefficients.
//
//  state | meaning
//  IDLE  | accepting samples and coefficient writes
//  ACCUM | stepping idx over the taps; last cycle drains the MAC pipeline
//  DONE  | result valid on out_data, waiting for out_ready
module correlation_stream
  import corr_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int COEF_W = 4,
  parameter  int TAPS   = 10,
  parameter  int SIGNED = 0,
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS),
  localparam int AW     = $clog2(TAPS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);

  localparam int IDX_W = idx_width(TAPS);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] win  [TAPS];
  logic [COEF_W-1:0] coef [TAPS];
  logic [IDX_W-1:0]  fill;
  logic [IDX_W-1:0]  idx;
  logic [AW-1:0]     sel;
  logic              hs_in;
  logic              start;
  logic              last;
  logic              coef_ok;
  logic              mac_en;
  logic              mac_clr;

  assign hs_in   = in_valid && in_ready;
  assign start   = hs_in && (fill >= IDX_W'(TAPS - 1));
  assign last    = (idx == IDX_W'(TAPS));
  assign coef_ok = coef_we && (state == IDLE) && (32'(coef_addr) < 32'(TAPS));
  assign mac_clr = clear || start;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = ACCUM;
        ACCUM:   if (last) state_nx = DONE;
        DONE:    if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mac_en    = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      ACCUM:   mac_en = !last;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Sliding window, fill count and tap index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill <= '0;
      idx  <= '0;
      for (int i = 0; i < TAPS; i++) win[i] <= '0;
    end else if (clear) begin
      fill <= '0;
      idx  <= '0;
      for (int i = 0; i < TAPS; i++) win[i] <= '0;
    end else begin
      if (hs_in) begin
        for (int i = 0; i < TAPS - 1; i++) win[i] <= win[i+1];
        win[TAPS-1] <= in_data;
        if (fill != IDX_W'(TAPS)) fill <= fill + 1'b1;
      end
      if (start) idx <= '0;
      else if ((state == ACCUM) && !last) idx <= idx + 1'b1;
    end
  end

  // Coefficient bank; writes only land while idle so an in-flight result is untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else if (!clear && coef_ok) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // Operand select; idx==TAPS is the drain cycle, where the operands are unused.
  always_comb begin
    sel = '0;
    if (idx < IDX_W'(TAPS)) sel = idx[AW-1:0];
  end

  corr_mac #(
    .A_W   (DATA_W),
    .B_W   (COEF_W),
    .ACC_W (ACC_W),
    .SIGNED(SIGNED)
  ) u_mac (
    .clock(clock),
    .reset(reset),
    .clr  (mac_clr),
    .en   (mac_en),
    .a    (win[sel]),
    .b    (coef[sel]),
    .acc  (out_data)
  );

endmodule

// File: tb/tb_correlation_stream.sv
// Bench: an unsigned and a signed correlator driven by the same stimulus,
// checked every cycle against a window/coefficient model.
module tb_correlation_stream;

  localparam int DATA_W = 4;
  localparam int COEF_W = 4;
  localparam int TAPS   = 10;
  localparam int ACC_W  = 12;
  localparam int AW     = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              clear = 1'b0;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b1;
  logic              in_ready_u, in_ready_s;
  logic              out_valid_u, out_valid_s;
  logic [ACC_W-1:0]  out_data_u, out_data_s;

  always #5 clock = ~clock;

  correlation_stream #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .SIGNED(0)) u_dut (
    .clock(clock), .reset(reset), .clear(clear), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .in_valid(in_valid),
    .in_ready(in_ready_u), .in_data(in_data), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_data(out_data_u));

  correlation_stream #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .SIGNED(1)) u_dut_s (
    .clock(clock), .reset(reset), .clear(clear), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .in_valid(in_valid),
    .in_ready(in_ready_s), .in_data(in_data), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s));

  int vectors     = 0;
  int miscompares = 0;

  // Model state: samples oldest first, coefficient bank, one pending result.
  int             win_q[$];
  int             coef_m[TAPS];
  bit             pend = 1'b0;
  int             due = 0;
  int             cyc = 0;
  int             results = 0;
  bit             last_hs = 1'b0;
  logic [ACC_W-1:0] exp_u, exp_s;
  logic [ACC_W-1:0] last_res_u, last_res_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sx(int v, int w, bit sgn);
    return (sgn && v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  function automatic logic [ACC_W-1:0] model_sum(bit sgn);
    int s = 0;
    for (int k = 0; k < TAPS; k++)
      s += sx(win_q[k], DATA_W, sgn) * sx(coef_m[k], COEF_W, sgn);
    return ACC_W'(s);
  endfunction

  // One clock: decide what the edge does from the model, advance, then compare.
  task automatic step();
    bit   hs_in, hs_out, we_ok;
    logic ov_exp;
    hs_in  = in_valid && !pend;
    hs_out = pend && (cyc >= due) && out_ready;
    we_ok  = coef_we && !pend && (int'(coef_addr) < TAPS);
    if (hs_out) begin
      last_res_u = out_data_u;
      last_res_s = out_data_s;
      results++;
    end
    @(posedge clock);
    #1;
    cyc++;
    last_hs = hs_in;
    if (clear) begin
      win_q.delete();
      pend = 1'b0;
    end else begin
      if (we_ok) coef_m[coef_addr] = int'(coef_data);
      if (hs_out) pend = 1'b0;
      if (hs_in) begin
        win_q.push_back(int'(in_data));
        if (win_q.size() > TAPS) void'(win_q.pop_front());
        if (win_q.size() == TAPS) begin
          pend  = 1'b1;
          due   = cyc + TAPS + 1;
          exp_u = model_sum(1'b0);
          exp_s = model_sum(1'b1);
        end
      end
    end
    ov_exp = pend && (cyc >= due);
    chk("in_ready_u", in_ready_u, !pend);
    chk("in_ready_s", in_ready_s, !pend);
    chk("out_valid_u", out_valid_u, ov_exp);
    chk("out_valid_s", out_valid_s, ov_exp);
    if (ov_exp) begin
      chk("out_data_u", out_data_u, exp_u);
      chk("out_data_s", out_data_s, exp_s);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; clear = 1'b0; coef_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid_u", out_valid_u, 0);
    chk("rst_out_valid_s", out_valid_s, 0);
    chk("rst_out_data_u", out_data_u, 0);
    chk("rst_out_data_s", out_data_s, 0);
    win_q.delete();
    pend = 1'b0;
    last_hs = 1'b0;
    for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    chk("rst_in_ready_u", in_ready_u, 1);
    chk("rst_in_ready_s", in_ready_s, 1);
  endtask

  task automatic send(input int v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = DATA_W'(v);
    do begin
      step();
      n++;
    end while (!last_hs && n < 200);
    if (!last_hs) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pend && n < 200) begin
      step();
      n++;
    end
    if (pend) chk("idle_timeout", 0, 1);
  endtask

  task automatic wr_coef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = COEF_W'(d);
    step();
    coef_we = 1'b0;
  endtask

  task automatic wr_all(input int d);
    for (int k = 0; k < TAPS; k++) wr_coef(k, d);
  endtask

  initial begin
    int r0;
    #3;
    // T1: reset values, then an all-zero coefficient bank gives 0
    do_reset();
    for (int k = 0; k < TAPS; k++) send(int'($urandom_range(0, 15)));
    wait_idle();
    chk("t1_zero_u", last_res_u, 0);

    // T2/T3: unit coefficients, ramp samples, then one more sample
    clear = 1'b1; step(); clear = 1'b0;
    wr_all(1);
    r0 = results;
    for (int v = 1; v <= TAPS; v++) send(v);
    wait_idle();
    chk("t2_sum", last_res_u, 55);
    chk("t2_count", results - r0, 1);
    send(11);
    wait_idle();
    chk("t3_sum", last_res_u, 65);

    // T4: extremes
    wr_all(15);
    for (int k = 0; k < TAPS; k++) begin send(15); wait_idle(); end
    chk("t4_u_max", last_res_u, 2250);
    chk("t4_s_m1", last_res_s, 10);
    wr_all(8);
    for (int k = 0; k < TAPS; k++) begin send(8); wait_idle(); end
    chk("t4_s_neg8", last_res_s, 640);
    wr_all(7);
    send(8);
    wait_idle();
    chk("t4_s_mix", last_res_s, 12'hDD0);
    chk("t4_u_mix", last_res_u, 560);

    // T5: backpressure with a held sample behind the stalled result
    out_ready = 1'b0;
    send(3);
    in_valid = 1'b1;
    in_data  = 4'd9;
    repeat (TAPS + 7) step();
    out_ready = 1'b1;
    begin
      int n = 0;
      do begin step(); n++; end while (!last_hs && n < 100);
      if (!last_hs) chk("t5_timeout", 0, 1);
    end
    in_valid = 1'b0;
    chk("t5_first", last_res_u, 525);
    wait_idle();
    chk("t5_second", last_res_u, 532);

    // T6: coefficient write during ACCUM is ignored
    send(1);
    coef_we = 1'b1; coef_addr = '0; coef_data = '0;
    wait_idle();
    coef_we = 1'b0;
    chk("t6_we_ignored", last_res_u, 483);

    // T6: clear mid-ACCUM drops the result and empties the window
    send(2);
    repeat (3) step();
    clear = 1'b1; step(); clear = 1'b0;
    r0 = results;
    for (int k = 0; k < TAPS - 1; k++) begin send(1); repeat (2) step(); end
    chk("t6_no_early", results - r0, 0);
    send(1);
    wait_idle();
    chk("t6_clear_sum", last_res_u, 70);
    chk("t6_clear_count", results - r0, 1);

    // T6: reset in DONE
    out_ready = 1'b0;
    send(5);
    repeat (TAPS + 3) step();
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      if (!in_valid || last_hs) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = DATA_W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      coef_we   = ($urandom_range(0, 5) == 0);
      coef_addr = AW'($urandom);
      coef_data = COEF_W'($urandom);
      clear     = ($urandom_range(0, 150) == 0);
      step();
    end
    clear = 1'b0; coef_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
